// File: rtl/wb_writeback.sv
// wb_writeback: MIPS writeback stage; queues retiring instructions, aligns/extends loads, drives regfile write port.
// Optional macro WB_FORWARD_EN builds head-entry forwarding outputs (fwd_*); otherwise they are tied to 0.
module wb_writeback #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rd,
  input  logic              in_regwrite,
  input  logic              in_memtoreg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [1:0]        in_load_size,
  input  logic              in_load_unsigned,
  input  logic              wb_hold,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] writedata,
  output logic              regwrite,
  output logic              misalign_err,
  output logic              fwd_valid,
  output logic [4:0]        fwd_rd,
  output logic [DATA_W-1:0] fwd_data
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]        q_rd   [DEPTH];
  logic              q_wr   [DEPTH];
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [AW-1:0]     head, tail;
  logic [AW:0]       count;
  logic [1:0]        off;
  logic [15:0]       sh;
  logic [DATA_W-1:0] load_data;
  logic              mis, push, pop, empty;
  assign off = in_alu_result[1:0];
  assign sh = 16'(in_mem_data >> {off, 3'b000});
  assign load_data = in_load_size == 2'b10 ? {{(DATA_W-8){~in_load_unsigned & sh[7]}}, sh[7:0]} :
                     in_load_size == 2'b01 ? {{(DATA_W-16){~in_load_unsigned & sh[15]}}, sh} :
                     in_mem_data;
  // size 11 is reserved and treated as a word load
  assign mis = in_memtoreg & (in_load_size == 2'b01 ? off[0] : in_load_size == 2'b10 ? 1'b0 : off != 2'b00);
  // DEPTH is a power of two, so the count MSB alone means full
  assign in_ready = ~count[AW];
  assign empty = count == '0;
  assign push = in_valid & in_ready;
  assign pop = ~empty & ~wb_hold;
  assign rd = empty ? 5'd0 : q_rd[head];
  assign writedata = empty ? '0 : q_data[head];
  assign regwrite = ~empty & q_wr[head] & ~wb_hold;
`ifdef WB_FORWARD_EN
  assign fwd_valid = ~empty & q_wr[head];
  assign fwd_rd = rd;
  assign fwd_data = writedata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd = 5'd0;
  assign fwd_data = '0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      misalign_err <= push & mis;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[tail] <= in_rd;
      q_wr[tail] <= in_regwrite & (in_rd != 5'd0) & ~mis;
      q_data[tail] <= in_memtoreg ? load_data : in_alu_result;
    end
  end
endmodule

// File: tb/tb_wb_writeback.sv
// tb_wb_writeback: directed scoreboard bench for wb_writeback; expected writes queued at drive, popped on regwrite.
module tb_wb_writeback;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_regwrite = 1'b0;
  logic        in_memtoreg = 1'b0;
  logic [31:0] in_alu_result = '0;
  logic [31:0] in_mem_data = '0;
  logic [1:0]  in_load_size = '0;
  logic        in_load_unsigned = 1'b0;
  logic        wb_hold = 1'b0;
  logic [4:0]  rd;
  logic [31:0] writedata;
  logic        regwrite;
  logic        misalign_err;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [36:0] sb [$];
  int total = 0;
  int bad = 0;
  wb_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_load_size(in_load_size), .in_load_unsigned(in_load_unsigned),
    .wb_hold(wb_hold), .rd(rd), .writedata(writedata), .regwrite(regwrite),
    .misalign_err(misalign_err), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      chk("write_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("write_rd_data", 64'({rd, writedata}), 64'(sb.pop_front()));
    end
  end
  task automatic set(input logic [4:0] r, input logic wr, input logic m2r, input logic [31:0] alu,
                     input logic [31:0] mem, input logic [1:0] sz, input logic uns);
    in_rd = r; in_regwrite = wr; in_memtoreg = m2r; in_alu_result = alu;
    in_mem_data = mem; in_load_size = sz; in_load_unsigned = uns;
  endtask
  task automatic push(input logic [4:0] r, input logic wr, input logic m2r, input logic [31:0] alu,
                      input logic [31:0] mem, input logic [1:0] sz, input logic uns,
                      input logic exp_wr, input logic [31:0] ed);
    int n;
    set(r, wr, m2r, alu, mem, sz, uns);
    in_valid = 1'b1;
    if (exp_wr) sb.push_back({r, ed});
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("push_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask
  initial begin
    #2;
    chk("rst_outputs", 64'({regwrite, rd, writedata, misalign_err}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_fwd", 64'({fwd_valid, fwd_rd, fwd_data}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push(5'd3, 1'b1, 1'b0, 32'h0000_0042, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0000_0042);
    chk("alu_latency", 64'({regwrite, rd, writedata}), 64'({1'b1, 5'd3, 32'h42}));
    @(posedge clk); #1;
    chk("alu_drained", 64'({regwrite, in_ready}), 64'b01);
    push(5'd4, 1'b1, 1'b1, 32'h0000_0003, 32'h80FF_7F01, 2'b10, 1'b0, 1'b1, 32'hFFFF_FF80);
    push(5'd6, 1'b1, 1'b1, 32'h0000_0003, 32'h80FF_7F01, 2'b10, 1'b1, 1'b1, 32'h0000_0080);
    push(5'd7, 1'b1, 1'b1, 32'h0000_0000, 32'h80FF_7F01, 2'b01, 1'b0, 1'b1, 32'h0000_7F01);
    push(5'd8, 1'b1, 1'b1, 32'h0000_0002, 32'h80FF_7F01, 2'b01, 1'b0, 1'b1, 32'hFFFF_80FF);
    push(5'd9, 1'b1, 1'b1, 32'h0000_0001, 32'h80FF_7F01, 2'b10, 1'b1, 1'b1, 32'h0000_007F);
    push(5'd10, 1'b1, 1'b1, 32'h0000_0000, 32'h80FF_7F01, 2'b11, 1'b0, 1'b1, 32'h80FF_7F01);
    @(posedge clk); #1;
    push(5'd0, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("r0_no_write", 64'(regwrite), 64'd0);
    @(posedge clk); #1;
    chk("r0_popped", 64'(in_ready), 64'd1);
    push(5'd5, 1'b1, 1'b1, 32'h0000_1002, 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("misalign_pulse", 64'({misalign_err, regwrite}), 64'b10);
    @(posedge clk); #1;
    chk("misalign_once", 64'(misalign_err), 64'd0);
    push(5'd11, 1'b1, 1'b1, 32'h0000_0001, 32'h1111_2222, 2'b01, 1'b0, 1'b0, 32'h0);
    chk("half_misalign", 64'({misalign_err, regwrite}), 64'b10);
    @(posedge clk); #1;
    wb_hold = 1'b1;
    push(5'd1, 1'b1, 1'b0, 32'h0000_0011, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0000_0011);
    push(5'd2, 1'b1, 1'b0, 32'h0000_0022, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0000_0022);
    set(5'd3, 1'b1, 1'b0, 32'h0000_0033, 32'h0, 2'b00, 1'b0);
    in_valid = 1'b1;
    chk("bp_full", 64'({in_ready, regwrite, rd}), 64'({1'b0, 1'b0, 5'd1}));
    @(posedge clk); #1;
    chk("bp_stalled", 64'({in_ready, regwrite, rd, writedata}), 64'({1'b0, 1'b0, 5'd1, 32'h11}));
    wb_hold = 1'b0;
    sb.push_back({5'd3, 32'h0000_0033});
    #1;
    chk("bp_rel_1", 64'({regwrite, rd}), 64'({1'b1, 5'd1}));
    @(posedge clk); #1;
    chk("bp_rel_2", 64'({in_ready, regwrite, rd}), 64'({1'b1, 1'b1, 5'd2}));
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_rel_3", 64'({regwrite, rd, writedata}), 64'({1'b1, 5'd3, 32'h33}));
    @(posedge clk); #1;
    chk("bp_drained", 64'({regwrite, in_ready}), 64'b01);
    wb_hold = 1'b1;
    push(5'd12, 1'b1, 1'b0, 32'h0000_00AA, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    push(5'd13, 1'b1, 1'b0, 32'h0000_00BB, 32'h0, 2'b00, 1'b0, 1'b0, 32'h0);
    chk("rstmid_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_outputs", 64'({regwrite, rd, writedata, misalign_err}), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd1);
    chk("rstmid_fwd", 64'({fwd_valid, fwd_rd, fwd_data}), 64'd0);
    wb_hold = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_no_stale", 64'({regwrite, in_ready}), 64'b01);
    wb_hold = 1'b1;
    push(5'd7, 1'b1, 1'b0, 32'h0000_1234, 32'h0, 2'b00, 1'b0, 1'b1, 32'h0000_1234);
`ifdef WB_FORWARD_EN
    chk("fwd_head", 64'({fwd_valid, fwd_rd, fwd_data}), 64'({1'b1, 5'd7, 32'h1234}));
`else
    chk("fwd_off", 64'({fwd_valid, fwd_rd, fwd_data}), 64'd0);
`endif
    chk("hold_no_write", 64'(regwrite), 64'd0);
    wb_hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
